// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants used by
// both the transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_SIZE  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, data LSB first, optional even parity, stop bit(s),
// timed from the shared 16x s_tick. Macro UART_TX_PARITY_EN inserts the parity bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int data_size  = DATA_SIZE,
  parameter int stop_ticks = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 tx_start,
  input  logic [data_size-1:0] tx_din,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  // The tick counter must also reach stop_ticks-1, which may exceed 15.
  localparam int TW = ($clog2(stop_ticks) > 4) ? $clog2(stop_ticks) : 4;
  localparam int BW = (data_size > 1) ? $clog2(data_size) : 1;
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(stop_ticks - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(data_size - 1);

  uart_state_t          r_state, w_state_next;
  logic [TW-1:0]        r_tick_cnt, w_tick_cnt_next;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic [data_size-1:0] r_shreg, w_shreg_next;
  logic                 r_tx, w_tx_next;
  logic                 r_done, w_done_next;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shreg    <= w_shreg_next;
      r_tx       <= w_tx_next;
      r_done     <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  // Line level is computed from the current state, so tx lags each transition by one clk.
  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shreg_next    = r_shreg;
    w_tx_next       = 1'b1;
    w_done_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_next   = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_shreg_next    = tx_din;
          w_tick_cnt_next = '0;
          w_bit_cnt_next  = '0;
          w_state_next    = START;
`ifdef UART_TX_PARITY_EN
          w_parity_next   = ^tx_din;
`endif
        end
      end
      START: begin
        w_tx_next = 1'b0;
        if (s_tick) begin
          if (r_tick_cnt == OS_LAST) begin
            w_tick_cnt_next = '0;
            w_state_next    = DATA;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        w_tx_next = r_shreg[0];
        if (s_tick) begin
          if (r_tick_cnt == OS_LAST) begin
            w_tick_cnt_next = '0;
            w_shreg_next    = r_shreg >> 1;
            if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              w_state_next = PARITY;
`else
              w_state_next = STOP;
`endif
            end else begin
              w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx_next = r_parity;
        if (s_tick) begin
          if (r_tick_cnt == OS_LAST) begin
            w_tick_cnt_next = '0;
            w_state_next    = STOP;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        w_tx_next = 1'b1;
        if (s_tick) begin
          if (r_tick_cnt == STOP_LAST) begin
            w_tick_cnt_next = '0;
            w_done_next     = 1'b1;
            w_state_next    = IDLE;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign tx           = r_tx;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done_tick = r_done;

endmodule
